// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter
// Round-robin arbiter and sequencer placed in front of a 2:1 data mux.
// Two requesters share one output path. The block grants one requester at a
// time and keeps that grant while its owner holds the request. The mux select
// is driven from a registered state. When both sides request from idle, the
// requester that was not granted most recently wins.
//
// Optional feature: define MUX2_ARB_TIMEOUT_EN to add a hold counter. With the
// counter, an owner that has held the path for TIMEOUT cycles is pre-empted
// if the other side is waiting. Without the macro the grant is held for as
// long as the owner requests.
module mux2_rr_arbiter #(
    parameter int DATA_W  = 1,
    parameter int TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic [DATA_W-1:0] d0,
    input  logic [DATA_W-1:0] d1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              s,
    output logic              valid,
    output logic [DATA_W-1:0] y
);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_GNT0 = 2'b01;
    localparam logic [1:0] ST_GNT1 = 2'b10;

    // The hold counter is 8 bits wide, so the hold limit must fit in it.
    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_timeout_range_check
        $error("mux2_rr_arbiter: TIMEOUT must be in 2..255");
    end

    logic [1:0] r_state;
    logic       r_last;     // index of the most recently granted requester
    logic       r_s;
    logic [1:0] w_next_state;
    logic       w_enter;    // a new grant starts at the coming edge
    logic       w_expired;  // the current owner has used up its hold budget

`ifdef MUX2_ARB_TIMEOUT_EN
    logic [7:0] r_cnt;

    assign w_expired = (r_cnt >= 8'(TIMEOUT - 1));

    // Hold counter: cleared on each grant entry, counts cycles spent in a grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 8'd0;
        end else if (w_enter) begin
            r_cnt <= 8'd0;
        end else if (r_state != ST_IDLE && r_cnt != 8'hFF) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end
`else
    // There is no hold limit, so an owner is never pre-empted.
    assign w_expired = 1'b0;
`endif

    // Next-state arbitration; the outputs depend only on registers
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req0 && !req1) begin
                    w_next_state = ST_GNT0;
                end else if (req1 && !req0) begin
                    w_next_state = ST_GNT1;
                end else if (req0 && req1) begin
                    w_next_state = r_last ? ST_GNT0 : ST_GNT1;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_GNT0: begin
                if (!req0) begin
                    w_next_state = req1 ? ST_GNT1 : ST_IDLE;
                end else if (w_expired && req1) begin
                    w_next_state = ST_GNT1;
                end else begin
                    w_next_state = ST_GNT0;
                end
            end
            ST_GNT1: begin
                if (!req1) begin
                    w_next_state = req0 ? ST_GNT0 : ST_IDLE;
                end else if (w_expired && req0) begin
                    w_next_state = ST_GNT0;
                end else begin
                    w_next_state = ST_GNT1;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    assign w_enter = (w_next_state != ST_IDLE) && (w_next_state != r_state);

    // State, round-robin pointer and registered mux select
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_last  <= 1'b1;
            r_s     <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_enter) begin
                r_last <= (w_next_state == ST_GNT1);
            end
            // The select changes only when a grant starts and holds through idle.
            if (w_next_state == ST_GNT1) begin
                r_s <= 1'b1;
            end else if (w_next_state == ST_GNT0) begin
                r_s <= 1'b0;
            end
        end
    end

    assign gnt0  = (r_state == ST_GNT0);
    assign gnt1  = (r_state == ST_GNT1);
    assign s     = r_s;
    assign valid = gnt0 | gnt1;
    assign y     = valid ? (r_s ? d1 : d0) : '0;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// tb_mux2_rr_arbiter
// Vector table plus hand sequences for reset, async reset mid-grant and
// long contention. Expected outputs are queued when stimulus is driven and
// popped/compared 1 time unit after the following rising edge.
// The DUT is built with DATA_W = 8 and TIMEOUT = 4. The contention sequence
// follows MUX2_ARB_TIMEOUT_EN.
module tb_mux2_rr_arbiter;

    typedef struct packed {
        logic       g0;
        logic       g1;
        logic       s;
        logic       v;
        logic [7:0] y;
    } out_t;

    typedef struct packed {
        logic       r0;
        logic       r1;
        logic [7:0] d0;
        logic [7:0] d1;
        out_t       exp;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       req0;
    logic       req1;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       gnt0;
    logic       gnt1;
    logic       s;
    logic       valid;
    logic [7:0] y;

    int   n_tests;
    int   n_fail;
    out_t exp_q[$];
    vec_t vecs[14];

    mux2_rr_arbiter #(
        .DATA_W (8),
        .TIMEOUT(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .req0 (req0),
        .req1 (req1),
        .d0   (d0),
        .d1   (d1),
        .gnt0 (gnt0),
        .gnt1 (gnt1),
        .s    (s),
        .valid(valid),
        .y    (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic out_t mk_out(input logic g0, input logic g1, input logic sel,
                                    input logic [7:0] yv);
        out_t o;
        o.g0 = g0;
        o.g1 = g1;
        o.s  = sel;
        o.v  = g0 | g1;
        o.y  = yv;
        return o;
    endfunction

    function automatic vec_t mk_vec(input logic r0, input logic r1, input logic [7:0] a,
                                    input logic [7:0] b, input out_t e);
        vec_t v;
        v.r0  = r0;
        v.r1  = r1;
        v.d0  = a;
        v.d1  = b;
        v.exp = e;
        return v;
    endfunction

    // Pop the oldest expectation and compare it against the live outputs.
    task automatic check_pop(input string name);
        out_t e;
        out_t act;
        act = {gnt0, gnt1, s, valid, y};
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("[TB] FAIL %s scoreboard empty, act=%h", name, act);
        end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
                n_fail++;
                $display("[TB] FAIL %s act g0=%b g1=%b s=%b v=%b y=%h, exp g0=%b g1=%b s=%b v=%b y=%h",
                         name, act.g0, act.g1, act.s, act.v, act.y, e.g0, e.g1, e.s, e.v, e.y);
            end else begin
                $display("[TB] ok   %s g0=%b g1=%b s=%b v=%b y=%h",
                         name, act.g0, act.g1, act.s, act.v, act.y);
            end
        end
    endtask

    // Drive one cycle of stimulus at the falling edge and check after the rising edge.
    task automatic step(input logic r0, input logic r1, input logic [7:0] a,
                        input logic [7:0] b, input out_t e, input string name);
        @(negedge clk);
        req0 = r0;
        req1 = r1;
        d0   = a;
        d1   = b;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check_pop(name);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        req0    = 1'b1;
        req1    = 1'b1;
        d0      = 8'hA5;
        d1      = 8'h3C;

        // Sequence starts in GNT0 with last = 0 and s = 0 (after the reset test).
        vecs[0]  = mk_vec(0, 0, 8'hA5, 8'h3C, mk_out(0, 0, 0, 8'h00)); // release -> idle
        vecs[1]  = mk_vec(0, 1, 8'h00, 8'h01, mk_out(0, 1, 1, 8'h01)); // single req1
        vecs[2]  = mk_vec(0, 0, 8'h00, 8'h01, mk_out(0, 0, 1, 8'h00)); // idle, s holds 1
        vecs[3]  = mk_vec(1, 0, 8'h5A, 8'hC3, mk_out(1, 0, 0, 8'h5A)); // single req0
        vecs[4]  = mk_vec(0, 0, 8'h5A, 8'hC3, mk_out(0, 0, 0, 8'h00)); // idle
        vecs[5]  = mk_vec(1, 1, 8'h11, 8'h22, mk_out(0, 1, 1, 8'h22)); // tie, last=0 -> 1
        vecs[6]  = mk_vec(1, 1, 8'h11, 8'h22, mk_out(0, 1, 1, 8'h22)); // owner holds
        vecs[7]  = mk_vec(0, 0, 8'h11, 8'h22, mk_out(0, 0, 1, 8'h00)); // idle
        vecs[8]  = mk_vec(1, 1, 8'h33, 8'h44, mk_out(1, 0, 0, 8'h33)); // tie, last=1 -> 0
        vecs[9]  = mk_vec(0, 1, 8'h55, 8'h66, mk_out(0, 1, 1, 8'h66)); // handover 0->1
        vecs[10] = mk_vec(1, 0, 8'h77, 8'h88, mk_out(1, 0, 0, 8'h77)); // handover 1->0
        vecs[11] = mk_vec(1, 1, 8'h99, 8'hAA, mk_out(1, 0, 0, 8'h99)); // owner holds
        vecs[12] = mk_vec(1, 0, 8'hBB, 8'hAA, mk_out(1, 0, 0, 8'hBB)); // y tracks d0
        vecs[13] = mk_vec(0, 0, 8'hBB, 8'hAA, mk_out(0, 0, 0, 8'h00)); // idle

        // Reset held with both requests high: nothing granted.
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(mk_out(0, 0, 0, 8'h00));
        check_pop("reset_hold");

        // Release: requester 0 wins the first tie on the first edge.
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(mk_out(1, 0, 0, 8'hA5));
        @(posedge clk);
        #1;
        check_pop("reset_release");

        for (int i = 0; i < 14; i++) begin
            step(vecs[i].r0, vecs[i].r1, vecs[i].d0, vecs[i].d1, vecs[i].exp,
                 $sformatf("vec%0d", i));
        end

        // Async reset between edges while in GNT1.
        step(0, 1, 8'h12, 8'h34, mk_out(0, 1, 1, 8'h34), "pre_async_gnt1");
        #3;
        rst_n = 1'b0;
        #1;
        exp_q.push_back(mk_out(0, 0, 0, 8'h00));
        check_pop("async_reset_mid_grant");
        @(negedge clk);
        req0  = 1'b0;
        req1  = 1'b0;
        rst_n = 1'b1;

        // Long contention from idle with last = 1: requester 0 gets the first grant.
        for (int k = 0; k < 24; k++) begin
            logic own0;
`ifdef MUX2_ARB_TIMEOUT_EN
            own0 = (((k / 4) % 2) == 0);
`else
            own0 = 1'b1;
`endif
            step(1, 1, 8'h0F, 8'hF0,
                 own0 ? mk_out(1, 0, 0, 8'h0F) : mk_out(0, 1, 1, 8'hF0),
                 $sformatf("contend%0d", k));
        end

        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL scoreboard_drain act=%0d leftover, exp=0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
